regfile_mp: RTL

Parametrised multi-port register file with per-register busy scoreboard; successor to the single-read 8×16 datapath register file. Provides one write port and two independent combinational read ports with write-through bypass, plus reserve/release tracking so the controller can stall on operands whose results are still pending. Sits in the datapath between the writeback mux and the A/B operand latches.

---
 rtl/regfile_mp.sv | 68 ++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: one-write, two-read register file with write-through bypass
// and a per-register busy scoreboard for operand stall detection.
module regfile_mp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write,
    input  logic [AW-1:0]    writenum,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rsv,
    input  logic [AW-1:0]    rsvnum,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    output logic             valid_a,
    output logic             valid_b,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      busy_count
);
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_next;
    logic             wr_en, rsv_en, zero_a, zero_b, byp_a, byp_b;

    assign wr_en  = write && !(ZERO_R0 && writenum == '0);
    assign rsv_en = rsv && !(ZERO_R0 && rsvnum == '0);

    // Reserve is applied after the release so a same-index collision ends busy.
    always_comb begin
        busy_next = busy;
        if (wr_en)
            busy_next[writenum] = 1'b0;
        if (rsv_en)
            busy_next[rsvnum] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_en)
                regs[writenum] <= data_in;
            busy <= busy_next;
        end
    end

    assign zero_a = ZERO_R0 && readnum_a == '0;
    assign zero_b = ZERO_R0 && readnum_b == '0;
    assign byp_a  = write && writenum == readnum_a;
    assign byp_b  = write && writenum == readnum_b;

    assign data_out_a = zero_a ? '0 : byp_a ? data_in : regs[readnum_a];
    assign data_out_b = zero_b ? '0 : byp_b ? data_in : regs[readnum_b];
    assign valid_a    = zero_a || byp_a || !busy[readnum_a];
    assign valid_b    = zero_b || byp_b || !busy[readnum_b];

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_count = busy_count + (AW+1)'(busy[i]);
    end
endmodule
